// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single memory unit.
// Each port holds one latched request; the granted one is issued, awaited, and answered.
`ifndef MEMORY_ADDR_WIDTH
`define MEMORY_ADDR_WIDTH 10
`endif
`ifndef MEMORY_DATA_WIDTH
`define MEMORY_DATA_WIDTH 16
`endif
`ifndef GET_CONTENTS
`define GET_CONTENTS 2'b01
`endif
`ifndef SET_CONTENTS
`define SET_CONTENTS 2'b10
`endif

module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_execute_0,
  input  logic [`MEMORY_ADDR_WIDTH-1:0] req_address_0,
  input  logic [1:0]                    req_func_0,
  input  logic [`MEMORY_DATA_WIDTH-1:0] req_write_data_0,
  input  logic                          req_execute_1,
  input  logic [`MEMORY_ADDR_WIDTH-1:0] req_address_1,
  input  logic [1:0]                    req_func_1,
  input  logic [`MEMORY_DATA_WIDTH-1:0] req_write_data_1,
  output logic                          ready_0,
  output logic [`MEMORY_DATA_WIDTH-1:0] read_data_0,
  output logic                          ready_1,
  output logic [`MEMORY_DATA_WIDTH-1:0] read_data_1,
  output logic                          mem_execute,
  output logic [`MEMORY_ADDR_WIDTH-1:0] mem_address,
  output logic [1:0]                    mem_func,
  output logic [`MEMORY_DATA_WIDTH-1:0] mem_write_data,
  input  logic                          mem_ready,
  input  logic [`MEMORY_DATA_WIDTH-1:0] mem_read_data,
  output logic                          grant,
  output logic                          busy,
  output logic                          overrun_0,
  output logic                          overrun_1,
  output logic                          timeout_err
);

  localparam int AW = `MEMORY_ADDR_WIDTH;
  localparam int DW = `MEMORY_DATA_WIDTH;
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic PORT_TRAVERSAL = 1'b0;
  localparam logic PORT_EXECUTE   = 1'b1;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [1:0]      pend_q, pend_d;
  logic [AW-1:0]   addr_q [2];
  logic [AW-1:0]   addr_d [2];
  logic [1:0]      func_q [2];
  logic [1:0]      func_d [2];
  logic [DW-1:0]   wdat_q [2];
  logic [DW-1:0]   wdat_d [2];
  logic [DW-1:0]   rdat_q [2];
  logic [DW-1:0]   rdat_d [2];
  logic            last_grant_q, last_grant_d;
  logic            grant_q, grant_d;
  logic            busy_q, busy_d;
  logic            mem_exec_q, mem_exec_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [1:0]      mem_func_q, mem_func_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [1:0]      ready_q, ready_d;
  logic [1:0]      ovr_q, ovr_d;
  logic            tmo_q, tmo_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [1:0]      req_s;
  logic [AW-1:0]   in_addr_s [2];
  logic [1:0]      in_func_s [2];
  logic [DW-1:0]   in_wdat_s [2];
  logic [1:0]      done_s;
  logic            win_s;
  logic [CW-1:0]   cnt_inc_s;

  assign req_s        = {req_execute_1, req_execute_0};
  assign in_addr_s[0] = req_address_0;
  assign in_addr_s[1] = req_address_1;
  assign in_func_s[0] = req_func_0;
  assign in_func_s[1] = req_func_1;
  assign in_wdat_s[0] = req_write_data_0;
  assign in_wdat_s[1] = req_write_data_1;

  // Arbitration, memory handshake, completion and request capture.
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    addr_d       = addr_q;
    func_d       = func_q;
    wdat_d       = wdat_q;
    rdat_d       = rdat_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    busy_d       = busy_q;
    mem_exec_d   = mem_exec_q;
    mem_addr_d   = mem_addr_q;
    mem_func_d   = mem_func_q;
    mem_wdata_d  = mem_wdata_q;
    ready_d      = 2'b00;
    ovr_d        = ovr_q;
    tmo_d        = tmo_q;
    cnt_d        = cnt_q;
    done_s       = 2'b00;
    cnt_inc_s    = cnt_q + CW'(1);

    if (pend_q == 2'b11) begin
      win_s = ~last_grant_q;
    end else if (pend_q[1]) begin
      win_s = PORT_EXECUTE;
    end else begin
      win_s = PORT_TRAVERSAL;
    end

    case (state_q)
      IDLE: begin
        if (pend_q != 2'b00) begin
          mem_exec_d  = 1'b1;
          mem_addr_d  = addr_q[win_s];
          mem_func_d  = func_q[win_s];
          mem_wdata_d = wdat_q[win_s];
          grant_d     = win_s;
          busy_d      = 1'b1;
          state_d     = ISSUE;
        end else begin
          mem_exec_d  = 1'b0;
        end
      end
      ISSUE: begin
        mem_exec_d = 1'b0;
        mem_func_d = 2'b00;
        cnt_d      = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        // The access is abandoned once TIMEOUT consecutive WAIT cycles pass without mem_ready.
        if (mem_ready) begin
          done_s[grant_q] = 1'b1;
          rdat_d[grant_q] = mem_read_data;
        end else if (cnt_inc_s == CW'(TIMEOUT)) begin
          done_s[grant_q] = 1'b1;
          rdat_d[grant_q] = '0;
          tmo_d           = 1'b1;
        end else begin
          cnt_d = cnt_inc_s;
        end
        if (done_s != 2'b00) begin
          ready_d[grant_q] = 1'b1;
          pend_d[grant_q]  = 1'b0;
          last_grant_d     = grant_q;
          busy_d           = 1'b0;
          state_d          = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A strobe landing on its own port's completion edge is kept: capture overrides the clear.
    for (int p = 0; p < 2; p++) begin
      if (req_s[p] && (!pend_q[p] || done_s[p])) begin
        pend_d[p] = 1'b1;
        addr_d[p] = in_addr_s[p];
        func_d[p] = in_func_s[p];
        wdat_d[p] = in_wdat_s[p];
      end else if (req_s[p]) begin
        ovr_d[p] = 1'b1;
      end else begin
        ovr_d[p] = ovr_d[p];
      end
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      pend_q       <= 2'b00;
      addr_q       <= '{default: '0};
      func_q       <= '{default: '0};
      wdat_q       <= '{default: '0};
      rdat_q       <= '{default: '0};
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      busy_q       <= 1'b0;
      mem_exec_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_func_q   <= 2'b00;
      mem_wdata_q  <= '0;
      ready_q      <= 2'b00;
      ovr_q        <= 2'b00;
      tmo_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      addr_q       <= addr_d;
      func_q       <= func_d;
      wdat_q       <= wdat_d;
      rdat_q       <= rdat_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      mem_exec_q   <= mem_exec_d;
      mem_addr_q   <= mem_addr_d;
      mem_func_q   <= mem_func_d;
      mem_wdata_q  <= mem_wdata_d;
      ready_q      <= ready_d;
      ovr_q        <= ovr_d;
      tmo_q        <= tmo_d;
      cnt_q        <= cnt_d;
    end
  end

  assign ready_0        = ready_q[0];
  assign ready_1        = ready_q[1];
  assign read_data_0    = rdat_q[0];
  assign read_data_1    = rdat_q[1];
  assign mem_execute    = mem_exec_q;
  assign mem_address    = mem_addr_q;
  assign mem_func       = mem_func_q;
  assign mem_write_data = mem_wdata_q;
  assign grant          = grant_q;
  assign busy           = busy_q;
  assign overrun_0      = ovr_q[0];
  assign overrun_1      = ovr_q[1];
  assign timeout_err    = tmo_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a latency-programmable memory responder plus
// hand-computed expectations for each scenario.
`ifndef MEMORY_ADDR_WIDTH
`define MEMORY_ADDR_WIDTH 10
`endif
`ifndef MEMORY_DATA_WIDTH
`define MEMORY_DATA_WIDTH 16
`endif
`ifndef GET_CONTENTS
`define GET_CONTENTS 2'b01
`endif

module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_execute_0 = 1'b0, req_execute_1 = 1'b0;
  logic [9:0]  req_address_0 = '0, req_address_1 = '0;
  logic [1:0]  req_func_0 = '0, req_func_1 = '0;
  logic [15:0] req_write_data_0 = '0, req_write_data_1 = '0;
  logic        ready_0, ready_1, mem_execute, mem_ready = 1'b0;
  logic [15:0] read_data_0, read_data_1, mem_write_data, mem_read_data = '0;
  logic [9:0]  mem_address;
  logic [1:0]  mem_func;
  logic        grant, busy, overrun_0, overrun_1, timeout_err;

  int checks = 0;
  int failures = 0;

  // Responder and monitors.
  int          mem_lat = 1;
  int          cd = -1;
  logic [9:0]  a_lat = '0;
  int          exec_cnt = 0, r0_cnt = 0, r1_cnt = 0, both_hi = 0, exec_wide = 0;
  logic        prev_exec = 1'b0;
  logic [9:0]  exec_addr [$];
  logic        exec_grant [$];
  localparam logic [15:0] RESP_BASE = 16'hABC8;

  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_execute_0(req_execute_0), .req_address_0(req_address_0),
    .req_func_0(req_func_0), .req_write_data_0(req_write_data_0),
    .req_execute_1(req_execute_1), .req_address_1(req_address_1),
    .req_func_1(req_func_1), .req_write_data_1(req_write_data_1),
    .ready_0(ready_0), .read_data_0(read_data_0),
    .ready_1(ready_1), .read_data_1(read_data_1),
    .mem_execute(mem_execute), .mem_address(mem_address), .mem_func(mem_func),
    .mem_write_data(mem_write_data), .mem_ready(mem_ready), .mem_read_data(mem_read_data),
    .grant(grant), .busy(busy), .overrun_0(overrun_0), .overrun_1(overrun_1),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    mem_ready     = 1'b0;
    mem_read_data = '0;
    if (cd == 0) begin
      mem_ready     = 1'b1;
      mem_read_data = RESP_BASE ^ {6'd0, a_lat};
      cd = -1;
    end else if (cd > 0) begin
      cd = cd - 1;
    end
    if (mem_execute) begin
      exec_cnt++;
      exec_addr.push_back(mem_address);
      exec_grant.push_back(grant);
      if (mem_lat > 0) begin
        cd    = mem_lat - 1;
        a_lat = mem_address;
      end
    end
    if (mem_execute && prev_exec) exec_wide++;
    prev_exec = mem_execute;
    if (ready_0) r0_cnt++;
    if (ready_1) r1_cnt++;
    if (ready_0 && ready_1) both_hi++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_execute_0 = 1'b0;
    req_execute_1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge; strobe is captured on the following posedge.
  task automatic strobe(input int port, input logic [9:0] addr);
    if (port == 0) begin
      req_execute_0 = 1'b1; req_address_0 = addr; req_func_0 = `GET_CONTENTS;
    end else begin
      req_execute_1 = 1'b1; req_address_1 = addr; req_func_1 = `GET_CONTENTS;
    end
    @(negedge clk);
    req_execute_0 = 1'b0;
    req_execute_1 = 1'b0;
  endtask

  task automatic wait_ready(input int port, input int budget, output int n, output logic [15:0] data);
    n = 0;
    while (n < budget && !((port == 0) ? ready_0 : ready_1)) begin
      @(negedge clk);
      n++;
    end
    data = (port == 0) ? read_data_0 : read_data_1;
    if (n >= budget) check_eq("ready_timeout", 32'(port), 32'hFFFF_FFFF);
  endtask

  initial begin
    int          n, base, got_port, rc0, rc1;
    logic [15:0] d;

    // Reset state.
    do_reset();
    check_eq("reset_outs", {26'd0, busy, grant, mem_execute, ready_0, ready_1, timeout_err}, 32'd0);
    check_eq("reset_ovr", {30'd0, overrun_1, overrun_0}, 32'd0);

    // Single read on port 0, memory answers 2 cycles after mem_execute.
    mem_lat = 2;
    base = exec_cnt;
    strobe(0, 10'h005);
    wait_ready(0, 20, n, d);
    check_eq("t1_latency", 32'(n), 32'd4);
    check_eq("t1_data", {16'd0, d}, 32'h0000_ABCD);
    @(negedge clk);
    check_eq("t1_ready_pulse", {31'd0, ready_0}, 32'd0);
    check_eq("t1_exec_cnt", 32'(exec_cnt - base), 32'd1);
    check_eq("t1_addr", {22'd0, exec_addr[base]}, 32'h5);
    check_eq("t1_no_ready1", 32'(r1_cnt), 32'd0);

    // Simultaneous strobes right after reset: port 0 wins first.
    do_reset();
    mem_lat = 1;
    base = exec_cnt;
    req_execute_1 = 1'b1; req_address_1 = 10'h002; req_func_1 = `GET_CONTENTS;
    strobe(0, 10'h001);
    wait_ready(0, 20, n, d);
    check_eq("t2_data0", {16'd0, d}, 32'h0000_ABC9);
    wait_ready(1, 20, n, d);
    check_eq("t2_data1", {16'd0, d}, 32'h0000_ABCA);
    check_eq("t2_addr_seq", {6'd0, exec_addr[base], 6'd0, exec_addr[base+1]}, 32'h0001_0002);
    check_eq("t2_grant_seq", {30'd0, exec_grant[base], exec_grant[base+1]}, 32'b01);

    // Continuous contention: grants alternate starting with port 0.
    @(negedge clk);
    base = exec_cnt;
    req_execute_1 = 1'b1; req_address_1 = 10'h200;
    strobe(0, 10'h100);
    for (int k = 0; k < 6; k++) begin
      n = 0;
      while (n < 40 && !ready_0 && !ready_1) begin
        @(negedge clk);
        n++;
      end
      if (n >= 40) check_eq("t3_ready_timeout", 32'(k), 32'hFFFF_FFFF);
      got_port = ready_1 ? 1 : 0;
      strobe(got_port, (got_port == 1) ? 10'h200 : 10'h100);
    end
    repeat (30) @(negedge clk);
    for (int i = 0; i < 6; i++)
      check_eq($sformatf("t3_grant%0d", i), {31'd0, exec_grant[base+i]}, 32'(i % 2));
    check_eq("t3_idle", {31'd0, busy}, 32'd0);

    // Double strobe while pending: overrun, single access with first address.
    mem_lat = 3;
    base = exec_cnt;
    strobe(0, 10'h007);
    strobe(0, 10'h008);
    wait_ready(0, 20, n, d);
    check_eq("t4_data", {16'd0, d}, 32'h0000_ABCF);
    repeat (10) @(negedge clk);
    check_eq("t4_exec_cnt", 32'(exec_cnt - base), 32'd1);
    check_eq("t4_addr", {22'd0, exec_addr[base]}, 32'h7);
    check_eq("t4_overrun", {30'd0, overrun_1, overrun_0}, 32'b01);

    // Memory never answers: abandoned after 4 WAIT cycles.
    mem_lat = -1;
    strobe(1, 10'h003);
    wait_ready(1, 30, n, d);
    check_eq("t5_latency", 32'(n), 32'd6);
    check_eq("t5_data_zero", {16'd0, d}, 32'd0);
    check_eq("t5_timeout_err", {31'd0, timeout_err}, 32'd1);
    @(negedge clk);
    check_eq("t5_idle", {30'd0, busy, ready_1}, 32'd0);

    // Reset during WAIT: everything clears at once, no ready pulse follows.
    strobe(0, 10'h004);
    repeat (3) @(negedge clk);
    check_eq("t6_busy_before", {31'd0, busy}, 32'd1);
    rc0 = r0_cnt;
    rc1 = r1_cnt;
    rst = 1'b0;
    #1;
    check_eq("t6_rst_outs", {25'd0, busy, grant, mem_execute, ready_0, ready_1, timeout_err, overrun_0}, 32'd0);
    check_eq("t6_rst_data", {read_data_0, read_data_1}, 32'd0);
    check_eq("t6_rst_addr", {22'd0, mem_address}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("t6_no_ready", 32'((r0_cnt - rc0) + (r1_cnt - rc1)), 32'd0);
    mem_lat = 1;
    strobe(1, 10'h009);
    wait_ready(1, 20, n, d);
    check_eq("t6_latency", 32'(n), 32'd3);
    check_eq("t6_data", {16'd0, d}, 32'h0000_ABC1);

    check_eq("never_both_ready", 32'(both_hi), 32'd0);
    check_eq("exec_one_cycle", 32'(exec_wide), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, the maximum number of WAIT cycles before a memory access is abandoned.
REQ-002 SHALL have parameter port names: port 0 = traversal requester, port 1 = execute requester.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 req_execute_N (N=0,1)  input  1  single-cycle request strobe from port N.
REQ-006 req_address_N  input  `memory_addr_width  target address, sampled with strobe.
REQ-007 req_func_N  input  2  `GET_CONTENTS / `SET_CONTENTS, sampled with strobe.
REQ-008 req_write_data_N  input  `memory_data_width  write payload, sampled with strobe.
REQ-009 ready_N  output  1  one-cycle completion pulse to port N.
REQ-010 read_data_N  output  `memory_data_width  data returned to port N, valid with ready_N, held until next completion for N.
REQ-011 mem_execute  output  1  request strobe to the memory unit.
REQ-012 mem_address  output  `memory_addr_width  address to the memory unit.
REQ-013 mem_func  output  2  function to the memory unit.
REQ-014 mem_write_data  output  `memory_data_width  write data to the memory unit.
REQ-015 mem_ready  input  1  memory unit completion.
REQ-016 mem_read_data  input  `memory_data_width  memory unit read data.
REQ-017 grant  output  1  port currently owning memory (0/1); valid when busy=1.
REQ-018 busy  output  1  high in ISSUE/WAIT.
REQ-019 overrun_N  output  1  sticky: strobe arrived while port N already pending.
REQ-020 timeout_err  output  1  sticky: an access exceeded TIMEOUT.

Function
REQ-021 Each port SHALL have a pending flag plus latched address/func/data, loaded on the edge where req_execute_N=1 and pending_N=0.
REQ-022 Strobe while pending_N=1 and not completing this cycle SHALL be dropped and set overrun_N.
REQ-023 Strobe on the same edge that completes port N SHALL be captured as a new pending request (capture wins over clear).
REQ-024 States SHALL be IDLE, ISSUE, WAIT.
REQ-025 IDLE: if any pending, select winner, drive mem_address/mem_func/mem_write_data from its latch, mem_execute<=1, grant<=winner, busy<=1, go ISSUE; else stay, mem_execute=0.
REQ-026 Arbitration SHALL be round-robin: if both pending, winner = !last_grant; if one pending, that port.
REQ-027 ISSUE: mem_execute<=0, mem_func<=0, clear timeout counter, go WAIT (mem_execute high exactly one cycle).
REQ-028 WAIT: when mem_ready=1, read_data_grant<=mem_read_data, ready_grant<=1 for one cycle, pending_grant cleared, last_grant<=grant, busy<=0, go IDLE.
REQ-029 WAIT: counter increments each cycle mem_ready=0; at count==TIMEOUT, set timeout_err, pulse ready_grant with read_data_grant<=0, clear pending_grant, last_grant<=grant, go IDLE.
REQ-030 Minimum latency strobe->ready_N SHALL be 3 cycles plus memory latency (capture, IDLE grant, ISSUE, WAIT completion).
REQ-031 A new grant SHALL NOT issue in the same cycle as a completion; next arbitration occurs in IDLE the following cycle.
REQ-032 ready_0 and ready_1 SHALL never be high simultaneously.
REQ-033 mem_ready seen outside WAIT SHALL be ignored.

Reset
REQ-034 On rst=0, immediately: state=IDLE, pending_0/1=0, last_grant=1 (port 0 wins first tie), all outputs 0, counter 0, sticky flags cleared.
REQ-035 Reset mid-access SHALL abandon the access with no ready pulse; in-flight requests are lost.

Verification
REQ-036 Port 0 read addr 10'h005, memory ready 2 cycles after mem_execute, data 'hABCD -> mem_execute one cycle with addr 5, ready_0 pulse, read_data_0='hABCD, ready_1 never.
REQ-037 Both ports strobe same cycle (addr 1, addr 2) after reset -> port 0 served first, then port 1; mem_address sequence 1,2; grant 0 then 1.
REQ-038 Port 1 continuously re-strobes after each ready_1 while port 0 pending -> grants alternate 0,1,0,...; no starvation.
REQ-039 Port 0 strobes twice while pending -> overrun_0=1, only one memory access issued.
REQ-040 mem_ready never asserts, TIMEOUT=4 -> after 4 WAIT cycles timeout_err=1, ready_N pulse with read_data_N=0, state IDLE.
REQ-041 rst asserted during WAIT -> all outputs 0 asynchronously, no ready pulse; subsequent request served normally.
